// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver: stores {error, data} per frame,
// hands frames to the host over valid/ready, and keeps sticky overrun/error statistics.
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int DROP_ERRORED = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_error,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_error,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic                  ovr_clr,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  overrun,
  output logic [7:0]            ovr_cnt,
  output logic [7:0]            err_cnt
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                pop;
  logic                push_req;
  logic                push_ok;
  logic                ovr_evt;
  logic                err_evt;

  // Status decode straight from the current pointers, so nothing lags the edge.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count     = wr_ptr - rd_ptr;
    out_valid = !empty;
    {out_error, out_data} = mem[rd_ptr[AW-1:0]];
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
  always_comb begin
    pop      = out_valid && out_ready;
    push_req = in_valid && !flush && !((DROP_ERRORED != 0) && in_error);
    push_ok  = push_req && (!full || pop);
    ovr_evt  = push_req && full && !pop;
    err_evt  = in_valid && in_error && !flush;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      ovr_cnt <= '0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr[AW-1:0]] <= {in_error, in_data};
          wr_ptr              <= wr_ptr + PTR_ONE;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end

      // A same-cycle event beats ovr_clr: the counter restarts at one instead of zero.
      if (ovr_evt) begin
        overrun <= 1'b1;
        ovr_cnt <= ovr_clr ? 8'd1 : sat_inc(ovr_cnt);
      end else if (ovr_clr) begin
        overrun <= 1'b0;
        ovr_cnt <= '0;
      end

      if (err_evt)      err_cnt <= ovr_clr ? 8'd1 : sat_inc(err_cnt);
      else if (ovr_clr) err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random traffic against a queue-based reference.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       in_valid = 1'b0, in_error = 1'b0, out_ready = 1'b0, flush = 1'b0, ovr_clr = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid, out_error, full, overrun;
  logic [7:0] out_data, ovr_cnt, err_cnt;
  logic [4:0] count;

  logic       d1_valid = 1'b0, d1_error = 1'b0;
  logic [7:0] d1_data = '0;
  logic       d1_out_valid, d1_out_error, d1_full, d1_overrun;
  logic [7:0] d1_out_data, d1_ovr_cnt, d1_err_cnt;
  logic [4:0] d1_count;

  int checks = 0;
  int failures = 0;

  logic [8:0] mq[$];
  logic       m_ovr = 1'b0;
  int         m_ocnt = 0;
  int         m_ecnt = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .out_valid(out_valid), .out_data(out_data), .out_error(out_error), .out_ready(out_ready),
    .flush(flush), .ovr_clr(ovr_clr), .count(count), .full(full), .overrun(overrun),
    .ovr_cnt(ovr_cnt), .err_cnt(err_cnt)
  );

  uart_rx_fifo #(.DROP_ERRORED(1)) dut_drop (
    .clk(clk), .arstn(arstn), .in_valid(d1_valid), .in_data(d1_data), .in_error(d1_error),
    .out_valid(d1_out_valid), .out_data(d1_out_data), .out_error(d1_out_error),
    .out_ready(1'b0), .flush(1'b0), .ovr_clr(1'b0), .count(d1_count), .full(d1_full),
    .overrun(d1_overrun), .ovr_cnt(d1_ovr_cnt), .err_cnt(d1_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ":count"}, 32'(count), 32'(mq.size()));
    chk({tag, ":full"}, 32'(full), 32'(mq.size() == 16));
    if (mq.size() != 0) begin
      chk({tag, ":out_data"}, 32'(out_data), 32'(mq[0][7:0]));
      chk({tag, ":out_error"}, 32'(out_error), 32'(mq[0][8]));
    end
    chk({tag, ":overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ":ovr_cnt"}, 32'(ovr_cnt), 32'(m_ocnt));
    chk({tag, ":err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
  endtask

  // One clock: apply inputs, advance the reference, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic rdy,
                      input logic fl, input logic oc);
    bit ovr_evt;
    in_valid = v; in_data = d; in_error = e; out_ready = rdy; flush = fl; ovr_clr = oc;
    ovr_evt = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < 16) mq.push_back({e, d});
        else ovr_evt = 1'b1;
      end
    end
    if (oc) begin m_ovr = 1'b0; m_ocnt = 0; m_ecnt = 0; end
    if (ovr_evt) begin m_ovr = 1'b1; m_ocnt = (m_ocnt == 255) ? 255 : m_ocnt + 1; end
    if (v && e && !fl) m_ecnt = (m_ecnt == 255) ? 255 : m_ecnt + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = '0; in_error = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
    d1_valid = 1'b0; d1_data = '0; d1_error = 1'b0;
  endtask

  initial begin
    int sent;
    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overrun", 32'(overrun), 0);
    #11 arstn = 1'b1;
    @(posedge clk); #1;

    // Single frame
    step(1, 8'hA5, 0, 0, 0, 0);
    check_all("single");
    chk("single_data", 32'(out_data), 32'h A5);
    chk("single_count", 32'(count), 1);
    step(0, 0, 0, 1, 0, 0);
    check_all("single_pop");
    chk("single_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Fill and overrun
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      check_all("fill");
    end
    step(1, 8'h10, 0, 0, 0, 0);
    check_all("overrun");
    chk("ovr_full", 32'(full), 1);
    chk("ovr_count", 32'(count), 16);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_cnt1", 32'(ovr_cnt), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(out_data), 32'(i));
      step(0, 0, 0, 1, 0, 0);
      check_all("drain");
    end
    chk("drain_empty", 32'(out_valid), 0);

    // Push while full with a simultaneous pop
    step(0, 0, 0, 0, 0, 1);
    check_all("clr");
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
    step(1, 8'h55, 0, 1, 0, 0);
    check_all("full_pushpop");
    chk("fpp_count", 32'(count), 16);
    chk("fpp_overrun", 32'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      chk("fpp_order", 32'(out_data), (i < 15) ? 32'(8'h21 + i) : 32'h55);
      step(0, 0, 0, 1, 0, 0);
    end
    check_all("fpp_drained");

    // Errored frames, kept by one instance and dropped by the other
    d1_valid = 1'b1; d1_data = 8'h3C; d1_error = 1'b1;
    step(1, 8'h3C, 1, 0, 0, 0);
    check_all("err_keep");
    chk("err_out_error", 32'(out_error), 1);
    chk("err_cnt1", 32'(err_cnt), 1);
    chk("drop_valid", 32'(d1_out_valid), 0);
    chk("drop_err_cnt", 32'(d1_err_cnt), 1);
    d1_valid = 1'b1; d1_data = 8'h12; d1_error = 1'b0;
    step(0, 0, 0, 1, 0, 0);
    check_all("err_pop");
    chk("drop_good_valid", 32'(d1_out_valid), 1);
    chk("drop_good_data", 32'(d1_out_data), 32'h12);
    chk("drop_count", 32'(d1_count), 1);

    // Flush racing a frame
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
    check_all("pre_flush");
    step(1, 8'h77, 1, 1, 1, 0);
    check_all("flush");
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);

    // ovr_clr racing an overrun
    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(1, 8'h99, 0, 0, 0, 0);
    step(1, 8'h9A, 0, 0, 0, 0);
    check_all("ovr2");
    step(1, 8'h9B, 0, 0, 0, 1);
    check_all("clr_race");
    chk("clr_race_ovr", 32'(overrun), 1);
    chk("clr_race_cnt", 32'(ovr_cnt), 1);
    step(0, 0, 0, 0, 1, 0);
    check_all("flush2");

    // Random stream across pointer wraps
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 40; cyc++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, 8'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 0, 0);
      if (v) sent++;
      check_all("rand");
      chk("rand_cnt_le16", 32'(count <= 5'd16), 1);
    end
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, 0, 0);

    // Asynchronous reset mid-stream
    arstn = 1'b0;
    #2;
    mq.delete(); m_ovr = 1'b0; m_ocnt = 0; m_ecnt = 0;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_error", 32'(out_error), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_ovr", 32'(overrun), 0);
    chk("arst_ovr_cnt", 32'(ovr_cnt), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    arstn = 1'b1;
    step(1, 8'hC3, 0, 0, 0, 0);
    check_all("post_rst");
    chk("post_rst_data", 32'(out_data), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver. It captures each received frame on the receiver's one-cycle done pulse, together with that frame's error flag, into a first-word-fall-through FIFO. It presents the frames to the host logic through a valid/ready interface. It also tracks overruns and errored frames so that software-visible status survives bursts of traffic.

## Interface
- DATA_WIDTH, 8, frame payload width; must equal the receiver's DATA_WIDTH.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- DROP_ERRORED, 0, when 1, frames arriving with in_error=1 are counted but not stored.
- AW, log2(DEPTH), derived localparam; not overridable.

Ports:
- clk  in  1  system clock.
- arstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  receiver done pulse; exactly one cycle per frame.
- in_data  in  DATA_WIDTH  frame data; valid only in the in_valid cycle (the receiver clears it the next cycle).
- in_error  in  1  parity/stop error for the frame; valid only in the in_valid cycle.
- out_valid  out  1  head entry available (= !empty).
- out_data  out  DATA_WIDTH  head entry data.
- out_error  out  1  head entry error flag.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- flush  in  1  synchronous clear of the stored contents.
- ovr_clr  in  1  clears overrun and ovr_cnt.
- count  out  AW+1  entries stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky: a frame was lost to full.
- ovr_cnt  out  8  frames lost to full; saturates at 255.
- err_cnt  out  8  frames received with in_error=1, stored or dropped; saturates at 255; cleared by ovr_clr.

## Operation
- Storage: DEPTH×(DATA_WIDTH+1) register array of {error, data}. Pointers wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit. empty = pointers equal; full = low bits equal and MSBs differ.
- pop = out_valid && out_ready: rd_ptr advances.
- push request = in_valid && !flush && !(DROP_ERRORED && in_error).
- Push is accepted when !full, or when full && pop in the same cycle. On accept, {in_error, in_data} is written at wr_ptr and wr_ptr advances.
- Push request while full with no pop: the frame is discarded, overrun is set, and ovr_cnt increments (saturating).
- The empty+push+pop case cannot occur: out_valid=0, so there is no pop; the push is accepted.
- err_cnt increments on every in_valid && in_error && !flush, independent of storage outcome.
- flush: next cycle wr_ptr = rd_ptr = 0 and count = 0. A same-cycle in_valid is dropped without counting as an overrun or error. A same-cycle pop is ignored. overrun, ovr_cnt and err_cnt are unaffected.
- ovr_clr: clears overrun, ovr_cnt and err_cnt. If an overrun or errored frame occurs in the same cycle, the set wins: overrun=1, ovr_cnt=1, err_cnt=1 as applicable.
- The block has no FSM beyond the pointers. All state is updated in one clocked process plus the combinational status decode.

## Timing
- Reset values: out_valid=0, out_data=0, out_error=0, count=0, full=0, overrun=0, ovr_cnt=0, err_cnt=0, both pointers=0, and array contents=0.
- Write latency: in_valid at edge N appears as out_valid=1 with out_data valid after edge N (one cycle), if the FIFO was empty.
- out_data and out_error are combinational reads of array[rd_ptr]. They are stable while out_valid=1 and no pop occurs.
- count, full and out_valid all reflect the post-edge pointers; they never lag by an extra cycle.
- Simultaneous push and pop: count is unchanged; the data order is preserved.
- Pointer wrap: after DEPTH pushes and DEPTH pops the pointers return to their low bits 0 with the MSB toggled; full and empty stay correct across the wrap.
- Asserting arstn mid-traffic discards all contents immediately; the first frame after release is stored at entry 0.

## Test plan
- Single frame: in_valid with in_data=0xA5, in_error=0, out_ready=0 → next cycle out_valid=1, out_data=0xA5, out_error=0, count=1. Raise out_ready for one cycle → out_valid=0, count=0.
- Fill and overrun (DEPTH=16): push 0x00..0x0F, then push 0x10 → full=1, count=16, overrun=1, ovr_cnt=1. Drain → 0x00..0x0F in order; 0x10 is absent.
- Push on full with pop: full, pop and push 0x55 in the same cycle → count stays 16, overrun=0, and 0x55 is read last.
- Error handling: with DROP_ERRORED=0, push 0x3C with in_error=1 → out_error=1, err_cnt=1. With DROP_ERRORED=1, the same stimulus → out_valid stays 0, err_cnt=1.
- Flush/clear races: with count=5, assert flush together with in_valid=0x77 → count=0, out_valid=0, ovr_cnt unchanged. Assert ovr_clr in the same cycle as an overrun → overrun=1, ovr_cnt=1.
- Wrap and reset: stream 40 frames with out_ready randomly toggling → output equals input order and count never exceeds 16. Assert arstn low mid-stream → all outputs return to their reset values within the same cycle.
